// File: rtl/sha256_msg_ctrl.sv
// SHA-256 message controller: accepts a byte stream, builds FIPS 180-4 padded
// 512-bit blocks (spilling into an extra block when needed) and sequences them to the core.
module sha256_msg_ctrl #(
    parameter int LEN_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic         in_ready,
    output logic         blk_valid,
    output logic [511:0] blk_data,
    output logic         blk_first,
    output logic         blk_last,
    input  logic         blk_ready,
    input  logic         core_done,
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MARK,
        S_ZERO,
        S_LEN,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       ptr_q, ptr_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;
    logic             mark_q, mark_d;
    logic             final_q, final_d;
    logic             pend_q, pend_d;
    logic             done_q, done_d;

    logic             wr_en;
    logic [5:0]       wr_addr;
    logic [7:0]       wr_byte;
    logic             len_en;
    logic [7:0]       buf_mem [64];
    logic [63:0]      bit_len;
    logic             accept;

    assign accept  = in_valid & in_ready;
    assign bit_len = 64'({cnt_q, 3'b000});

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        mark_d  = mark_q;
        final_d = final_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        wr_addr = ptr_q;
        wr_byte = 8'h00;
        len_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                ptr_d   = 6'd0;
                cnt_d   = '0;
                first_d = 1'b1;
                mark_d  = 1'b0;
                final_d = 1'b0;
                pend_d  = 1'b0;
                if (accept) begin
                    wr_en   = 1'b1;
                    wr_addr = 6'd0;
                    wr_byte = in_data;
                    ptr_d   = 6'd1;
                    cnt_d   = LEN_W'(1);
                    state_d = in_last ? S_MARK : S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    wr_en   = 1'b1;
                    wr_byte = in_data;
                    ptr_d   = ptr_q + 6'd1;
                    cnt_d   = cnt_q + LEN_W'(1);
                    if (ptr_q == 6'd63) begin
                        // Block full: the marker, if due, goes into the next block.
                        pend_d  = in_last;
                        state_d = S_ISSUE;
                    end else if (in_last) begin
                        state_d = S_MARK;
                    end
                end
            end
            S_MARK: begin
                wr_en   = 1'b1;
                wr_byte = 8'h80;
                ptr_d   = ptr_q + 6'd1;
                mark_d  = 1'b1;
                state_d = (ptr_q == 6'd63) ? S_ISSUE : S_ZERO;
            end
            S_ZERO: begin
                wr_en   = 1'b1;
                wr_byte = 8'h00;
                ptr_d   = ptr_q + 6'd1;
                // Marker at 56..63 leaves ptr above 56, so this block is zero-filled and spilled.
                if (ptr_q == 6'd55 || ptr_q == 6'd56) begin
                    state_d = S_LEN;
                end else if (ptr_q == 6'd63) begin
                    state_d = S_ISSUE;
                end
            end
            S_LEN: begin
                len_en  = 1'b1;
                final_d = 1'b1;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (blk_ready) begin
                    first_d = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (core_done) begin
                    ptr_d = 6'd0;
                    if (final_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else if (mark_q) begin
                        state_d = S_ZERO;
                    end else if (pend_q) begin
                        pend_d  = 1'b0;
                        state_d = S_MARK;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ptr_q   <= 6'd0;
            cnt_q   <= '0;
            first_q <= 1'b1;
            mark_q  <= 1'b0;
            final_q <= 1'b0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            mark_q  <= mark_d;
            final_q <= final_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) begin
                buf_mem[i] <= 8'h00;
            end
        end else if (len_en) begin
            for (int k = 0; k < 8; k++) begin
                buf_mem[56 + k] <= bit_len[63 - 8 * k -: 8];
            end
        end else if (wr_en) begin
            buf_mem[wr_addr] <= wr_byte;
        end
    end

    always_comb begin
        blk_data = '0;
        for (int i = 0; i < 64; i++) begin
            blk_data[511 - 8 * i -: 8] = buf_mem[i];
        end
    end

    assign in_ready  = rst & ((state_q == S_IDLE) | (state_q == S_LOAD));
    assign blk_valid = (state_q == S_ISSUE);
    assign blk_first = blk_valid & first_q;
    assign blk_last  = blk_valid & final_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;

endmodule
